// File: rtl/byte_lsu.sv
// Byte-serial load/store initiator: splits one RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW
// into 1, 2 or 4 little-endian byte accesses. Optional MISALIGN_TRAP_EN rejects misaligned halves/words.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a request; latches fields on req_valid
// XFER   | one memory byte access per cycle, byte index k_q
// RESP   | one-cycle response pulse, then back to IDLE
module byte_lsu #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [1:0]        k_q;
  logic [1:0]        left_q;

  logic              req_legal;
  logic [1:0]        n_last;
  logic [31:0]       load_ext;

  // Legality of the incoming request, evaluated only while IDLE.
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !req_we;
      default:                req_legal = 1'b0;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_legal = 1'b0;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      req_legal = 1'b0;
`endif
  end

  // Index of the last byte (N-1); loads the down-counter on accept.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   n_last = 2'd0;
      2'b01:   n_last = 2'd1;
      default: n_last = 2'd3;
    endcase
  end

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{24{rdata_q[7]}}, rdata_q[7:0]};
      3'b001:  load_ext = {{16{rdata_q[15]}}, rdata_q[15:0]};
      3'b010:  load_ext = rdata_q;
      3'b100:  load_ext = {24'd0, rdata_q[7:0]};
      3'b101:  load_ext = {16'd0, rdata_q[15:0]};
      default: load_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'd0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_d = req_legal ? S_XFER : S_RESP;
      end
      S_XFER: begin
        mem_re    = !we_q;
        mem_we    = we_q;
        mem_addr  = addr_q + ADDR_W'(k_q);
        mem_wdata = wdata_q[{k_q, 3'b000} +: 8];
        if (left_q == 2'd0)
          state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'd0 : load_ext;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, byte index (up) and remaining-byte count (down, terminal at 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      k_q     <= 2'd0;
      left_q  <= 2'd0;
    end else if (state_q == S_IDLE && req_valid) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= 32'd0;
      err_q   <= !req_legal;
      k_q     <= 2'd0;
      left_q  <= n_last;
    end else if (state_q == S_XFER) begin
      if (!we_q)
        rdata_q[{k_q, 3'b000} +: 8] <= mem_rdata;
      k_q    <= k_q + 2'd1;
      left_q <= left_q - 2'd1;
    end
  end

endmodule

// File: tb/tb_byte_lsu.sv
// Self-checking bench for byte_lsu: directed vectors, back-to-back/busy behaviour,
// randomized requests against a byte-array reference model, and mid-operation reset.
module tb_byte_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  byte_lsu #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       load_mem = 1'b0;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct packed {
    logic [7:0] cyc;
    logic       re;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wd;
  } strobe_t;

  strobe_t     obs_q[$];
  strobe_t     exp_q[$];
  int          obs_resp_cyc, obs_ready_cyc, obs_resp_cnt;
  logic [31:0] obs_rdata;
  logic        obs_err;
  bit          obs_overlap;
  int          exp_resp_cyc, exp_ready_cyc;
  logic [31:0] exp_rdata;
  logic        exp_err;

  // Reference model: expected strobe trace and response from the access rules on a byte array.
  task automatic model_req(input bit we, input logic [2:0] f3, input logic [7:0] addr,
                           input logic [31:0] wd);
    bit          legal;
    int          n;
    logic [31:0] w;
    byte         sb;
    shortint     sh;
    exp_q.delete();
    if (we) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
    if (n == 2 && (addr % 2) != 0) legal = 0;
    if (n == 4 && (addr % 4) != 0) legal = 0;
`endif
    if (!legal) begin
      exp_resp_cyc  = 1;
      exp_ready_cyc = 2;
      exp_rdata     = 32'd0;
      exp_err       = 1'b1;
      return;
    end
    w = 32'd0;
    for (int k = 0; k < n; k++) begin
      logic [7:0] a;
      a = 8'(int'(addr) + k);
      exp_q.push_back('{cyc: 8'(k + 1), re: !we, we: we, addr: a, wd: 8'(wd >> (8 * k))});
      w = w | (32'(ref_mem[a]) << (8 * k));
      if (we) ref_mem[a] = 8'(wd >> (8 * k));
    end
    exp_resp_cyc  = n + 1;
    exp_ready_cyc = n + 2;
    exp_err       = 1'b0;
    sb = byte'(w[7:0]);
    sh = shortint'(w[15:0]);
    if (we) exp_rdata = 32'd0;
    else case (f3)
      3'd0:    exp_rdata = 32'(int'(sb));
      3'd1:    exp_rdata = 32'(int'(sh));
      3'd2:    exp_rdata = w;
      3'd4:    exp_rdata = w & 32'hFF;
      default: exp_rdata = w & 32'hFFFF;
    endcase
  endtask

  // Drives one request and records what the DUT does, cycle by cycle after acceptance.
  task automatic run_req(input bit we, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [31:0] wd);
    int w;
    obs_q.delete();
    obs_resp_cyc  = -1;
    obs_ready_cyc = -1;
    obs_resp_cnt  = 0;
    obs_rdata     = 32'd0;
    obs_err       = 1'b0;
    obs_overlap   = 0;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = 8'($urandom);
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    req_we     = 1'($urandom);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_re || mem_we) begin
        obs_q.push_back('{cyc: 8'(c), re: mem_re, we: mem_we, addr: mem_addr, wd: mem_wdata});
        if (resp_valid) obs_overlap = 1;
      end
      if (resp_valid) begin
        obs_resp_cnt++;
        obs_resp_cyc = c;
        obs_rdata    = resp_rdata;
        obs_err      = resp_err;
      end
      if (req_ready) begin
        obs_ready_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [52:0] got;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_funct3 = 3'd0;
    req_addr  = 8'd0;
    req_wdata = 32'd0;
    load_mem  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    load_mem = 1'b0;
    got = {req_ready, resp_valid, resp_err, resp_rdata, mem_re, mem_we, mem_addr, mem_wdata};
    n_vec++;
    if (got !== {1'b1, 52'd0}) begin
      n_miss++;
      $display("FAIL reset_values got %h want %h", got, {1'b1, 52'd0});
    end
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } dvec_t;

  task automatic test_directed();
    dvec_t dv[$];
    dv.push_back('{we: 1'b0, f3: 3'd0, addr: 8'd12, wd: 32'd0, rd: 32'hFFFFFFFF, err: 1'b0});
    dv.push_back('{we: 1'b0, f3: 3'd4, addr: 8'd12, wd: 32'd0, rd: 32'h000000FF, err: 1'b0});
    dv.push_back('{we: 1'b1, f3: 3'd2, addr: 8'd40, wd: 32'hDEADBEEF, rd: 32'd0, err: 1'b0});
    dv.push_back('{we: 1'b0, f3: 3'd2, addr: 8'd40, wd: 32'd0, rd: 32'hDEADBEEF, err: 1'b0});
`ifdef MISALIGN_TRAP_EN
    dv.push_back('{we: 1'b1, f3: 3'd1, addr: 8'd255, wd: 32'h00001234, rd: 32'd0, err: 1'b1});
    dv.push_back('{we: 1'b0, f3: 3'd2, addr: 8'd2, wd: 32'd0, rd: 32'd0, err: 1'b1});
    dv.push_back('{we: 1'b1, f3: 3'd1, addr: 8'd2, wd: 32'h0000A5C3, rd: 32'd0, err: 1'b0});
    dv.push_back('{we: 1'b0, f3: 3'd1, addr: 8'd2, wd: 32'd0, rd: 32'hFFFFA5C3, err: 1'b0});
`else
    dv.push_back('{we: 1'b1, f3: 3'd1, addr: 8'd255, wd: 32'h00001234, rd: 32'd0, err: 1'b0});
    dv.push_back('{we: 1'b0, f3: 3'd5, addr: 8'd255, wd: 32'd0, rd: 32'h00001234, err: 1'b0});
`endif
    dv.push_back('{we: 1'b0, f3: 3'd3, addr: 8'd7, wd: 32'd0, rd: 32'd0, err: 1'b1});
    dv.push_back('{we: 1'b1, f3: 3'd4, addr: 8'd7, wd: 32'h55AA55AA, rd: 32'd0, err: 1'b1});
    foreach (dv[j]) begin
      model_req(dv[j].we, dv[j].f3, dv[j].addr, dv[j].wd);
      run_req(dv[j].we, dv[j].f3, dv[j].addr, dv[j].wd);
      n_vec++;
      if (obs_rdata !== dv[j].rd || obs_err !== dv[j].err) begin
        n_miss++;
        $display("FAIL directed_%0d_resp got rdata=%h err=%b want rdata=%h err=%b",
                 j, obs_rdata, obs_err, dv[j].rd, dv[j].err);
      end
      n_vec++;
      if (obs_resp_cyc !== exp_resp_cyc || obs_ready_cyc !== exp_ready_cyc || obs_resp_cnt !== 1) begin
        n_miss++;
        $display("FAIL directed_%0d_timing got resp@%0d ready@%0d pulses=%0d want resp@%0d ready@%0d pulses=1",
                 j, obs_resp_cyc, obs_ready_cyc, obs_resp_cnt, exp_resp_cyc, exp_ready_cyc);
      end
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
        n_miss++;
        $display("FAIL directed_%0d_strobe_count got %0d want %0d", j, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_miss++;
          $display("FAIL directed_%0d_strobe_%0d got %h want %h", j, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a1 = 8'h80, a2 = 8'h81;
    logic [31:0] d1 = 32'h000000C7, d2 = 32'h0000005E;
    int          w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_we = 1'b1; req_funct3 = 3'd0; req_addr = a1; req_wdata = d1; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_addr  = a2;
    req_wdata = d2;
    @(negedge clk);
    n_vec++;
    if ({mem_we, mem_re, mem_addr, mem_wdata, resp_valid, req_ready} !== {1'b1, 1'b0, a1, d1[7:0], 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL b2b_first_strobe got we=%b re=%b addr=%h wd=%h rv=%b rdy=%b want we=1 re=0 addr=%h wd=%h rv=0 rdy=0",
               mem_we, mem_re, mem_addr, mem_wdata, resp_valid, req_ready, a1, d1[7:0]);
    end
    @(negedge clk);
    n_vec++;
    if ({resp_valid, resp_err, req_ready, mem_we} !== 4'b1000) begin
      n_miss++;
      $display("FAIL b2b_first_resp got rv/err/rdy/we=%b want 1000", {resp_valid, resp_err, req_ready, mem_we});
    end
    @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, mem_we} !== 3'b100) begin
      n_miss++;
      $display("FAIL b2b_ready got rdy/rv/we=%b want 100", {req_ready, resp_valid, mem_we});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, a2, d2[7:0]}) begin
      n_miss++;
      $display("FAIL b2b_second_strobe got we=%b addr=%h wd=%h want we=1 addr=%h wd=%h",
               mem_we, mem_addr, mem_wdata, a2, d2[7:0]);
    end
    @(negedge clk);
    n_vec++;
    if (resp_valid !== 1'b1) begin
      n_miss++;
      $display("FAIL b2b_second_resp got %b want 1", resp_valid);
    end
    ref_mem[a1] = d1[7:0];
    ref_mem[a2] = d2[7:0];
  endtask

  task automatic test_random();
    for (int j = 0; j < 40; j++) begin
      bit          we;
      logic [2:0]  f3;
      logic [7:0]  addr;
      logic [31:0] wd;
      we   = 1'($urandom);
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom);
      wd   = $urandom;
      model_req(we, f3, addr, wd);
      run_req(we, f3, addr, wd);
      n_vec++;
      if (obs_rdata !== exp_rdata || obs_err !== exp_err) begin
        n_miss++;
        $display("FAIL random_%0d_resp we=%b f3=%0d addr=%h got rdata=%h err=%b want rdata=%h err=%b",
                 j, we, f3, addr, obs_rdata, obs_err, exp_rdata, exp_err);
      end
      n_vec++;
      if (obs_resp_cyc !== exp_resp_cyc || obs_ready_cyc !== exp_ready_cyc ||
          obs_resp_cnt !== 1 || obs_overlap !== 1'b0) begin
        n_miss++;
        $display("FAIL random_%0d_timing got resp@%0d ready@%0d pulses=%0d overlap=%0d want resp@%0d ready@%0d pulses=1 overlap=0",
                 j, obs_resp_cyc, obs_ready_cyc, obs_resp_cnt, obs_overlap, exp_resp_cyc, exp_ready_cyc);
      end
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
        n_miss++;
        $display("FAIL random_%0d_strobe_count got %0d want %0d", j, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_miss++;
          $display("FAIL random_%0d_strobe_%0d got %h want %h", j, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  old22, old23;
    logic [52:0] got;
    int          w = 0;
    int          rv_seen = 0;
    int          we_seen = 0;
    old22 = ref_mem[22];
    old23 = ref_mem[23];
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 8'd20; req_wdata = 32'h3B9ACA01; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    got = {req_ready, resp_valid, resp_err, resp_rdata, mem_re, mem_we, mem_addr, mem_wdata};
    n_vec++;
    if (got !== {1'b1, 52'd0}) begin
      n_miss++;
      $display("FAIL midreset_outputs got %h want %h", got, {1'b1, 52'd0});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
      if (mem_we || mem_re) we_seen++;
    end
    n_vec++;
    if (rv_seen != 0 || we_seen != 0) begin
      n_miss++;
      $display("FAIL midreset_quiet got resp_pulses=%0d strobes=%0d want 0 0", rv_seen, we_seen);
    end
    n_vec++;
    if ({mem[20], mem[21], mem[22], mem[23]} !== {8'h01, 8'hCA, old22, old23}) begin
      n_miss++;
      $display("FAIL midreset_mem got %h %h %h %h want 01 ca %h %h",
               mem[20], mem[21], mem[22], mem[23], old22, old23);
    end
    ref_mem[20] = 8'h01;
    ref_mem[21] = 8'hCA;
  endtask

  task automatic test_mem_image();
    int diffs = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    n_vec++;
    if (diffs != 0) begin
      n_miss++;
      $display("FAIL mem_image got %0d differing bytes want 0", diffs);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    for (int i = 12; i < 16; i++) ref_mem[i] = 8'hFF;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_mem_image();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
